fpu_issue_ctrl: RTL and testbench

//  Sequences single-precision ops into the combinational FPU datapath for the RISCV32F core.

---
 rtl/fpu_issue_ctrl.sv | 166 ++++++++++++++++
 tb/tb_fpu_issue_ctrl.sv | 285 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/fpu_issue_ctrl.sv
// Issue controller for the single-precision FPU: registers one op, holds it on the
// combinational datapath for a per-class window, captures result/flags and accrues fflags.
module fpu_issue_ctrl #(
  parameter int unsigned ADD_LAT  = 2,
  parameter int unsigned MUL_LAT  = 3,
  parameter int unsigned CVT_LAT  = 2,
  parameter int unsigned MISC_LAT = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        req_valid,
  output logic        req_ready,
  input  logic [31:0] req_a,
  input  logic [31:0] req_b,
  input  logic [3:0]  req_op,
  input  logic        req_sub,
  input  logic [2:0]  req_rm,
  input  logic [4:0]  req_rd,
  input  logic [2:0]  csr_frm,
  output logic [31:0] fpu_a,
  output logic [31:0] fpu_b,
  output logic [2:0]  fpu_frm,
  output logic [3:0]  fpu_decode,
  output logic        fpu_sub,
  input  logic [31:0] fpu_result,
  input  logic [4:0]  fpu_flags,
  output logic        resp_valid,
  input  logic        resp_ready,
  output logic [31:0] resp_result,
  output logic [4:0]  resp_flags,
  output logic [4:0]  resp_rd,
  output logic        resp_illegal,
  output logic [4:0]  fflags,
  input  logic        fflags_clr
);

  typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

  state_t      state_q, state_d;
  logic [3:0]  cnt_q, cnt_d;
  logic [31:0] a_q, a_d;
  logic [31:0] b_q, b_d;
  logic [2:0]  frm_q, frm_d;
  logic [3:0]  op_q, op_d;
  logic        sub_q, sub_d;
  logic [4:0]  rd_q, rd_d;
  logic [31:0] res_q, res_d;
  logic [4:0]  rflags_q, rflags_d;
  logic        ill_q, ill_d;
  logic [4:0]  fflags_q, fflags_d;

  logic [2:0]  rm_eff;
  logic        req_illegal;
  logic [4:0]  fflags_base;

  function automatic logic [3:0] lat_m1(input logic [3:0] op);
    logic [3:0] r;
    case (op)
      4'd0:       r = 4'(ADD_LAT - 1);
      4'd1, 4'd2: r = 4'(CVT_LAT - 1);
      4'd3:       r = 4'(MUL_LAT - 1);
      default:    r = 4'(MISC_LAT - 1);
    endcase
    return r;
  endfunction

  assign rm_eff      = (req_rm == 3'b111) ? csr_frm : req_rm;
  assign req_illegal = (rm_eff == 3'b101) || (rm_eff == 3'b110) || (rm_eff == 3'b111) ||
                       (req_op > 4'd8);
  assign fflags_base = fflags_clr ? '0 : fflags_q;

  always_comb begin
    state_d  = state_q;
    cnt_d    = cnt_q;
    a_d      = a_q;
    b_d      = b_q;
    frm_d    = frm_q;
    op_d     = op_q;
    sub_d    = sub_q;
    rd_d     = rd_q;
    res_d    = res_q;
    rflags_d = rflags_q;
    ill_d    = ill_q;
    fflags_d = fflags_base;

    case (state_q)
      IDLE: begin
        if (req_valid) begin
          a_d   = req_a;
          b_d   = req_b;
          op_d  = req_op;
          sub_d = req_sub;
          rd_d  = req_rd;
          frm_d = rm_eff;
          ill_d = req_illegal;
          // Illegal ops take a single pass-through EXEC cycle and never sample the FPU.
          cnt_d   = req_illegal ? '0 : lat_m1(req_op);
          state_d = EXEC;
        end
      end
      EXEC: begin
        if (cnt_q == '0) begin
          if (ill_q) begin
            res_d    = '0;
            rflags_d = '0;
          end else begin
            res_d    = fpu_result;
            rflags_d = fpu_flags;
            fflags_d = fflags_base | fpu_flags;
          end
          state_d = DONE;
        end else begin
          cnt_d = cnt_q - 4'd1;
        end
      end
      DONE: begin
        if (resp_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      cnt_q    <= '0;
      a_q      <= '0;
      b_q      <= '0;
      frm_q    <= '0;
      op_q     <= '0;
      sub_q    <= 1'b0;
      rd_q     <= '0;
      res_q    <= '0;
      rflags_q <= '0;
      ill_q    <= 1'b0;
      fflags_q <= '0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      a_q      <= a_d;
      b_q      <= b_d;
      frm_q    <= frm_d;
      op_q     <= op_d;
      sub_q    <= sub_d;
      rd_q     <= rd_d;
      res_q    <= res_d;
      rflags_q <= rflags_d;
      ill_q    <= ill_d;
      fflags_q <= fflags_d;
    end
  end

  assign req_ready    = (state_q == IDLE);
  assign resp_valid   = (state_q == DONE);
  assign fpu_a        = a_q;
  assign fpu_b        = b_q;
  assign fpu_frm      = frm_q;
  assign fpu_decode   = op_q;
  assign fpu_sub      = sub_q;
  assign resp_result  = res_q;
  assign resp_flags   = rflags_q;
  assign resp_rd      = rd_q;
  assign resp_illegal = ill_q;
  assign fflags       = fflags_q;

endmodule

// File: tb/tb_fpu_issue_ctrl.sv
// Directed bench for fpu_issue_ctrl; the bench plays the FPU by driving result/flags.
module tb_fpu_issue_ctrl;

  logic        clk = 1'b0;
  logic        reset;
  logic        req_valid, req_ready;
  logic [31:0] req_a, req_b;
  logic [3:0]  req_op;
  logic        req_sub;
  logic [2:0]  req_rm;
  logic [4:0]  req_rd;
  logic [2:0]  csr_frm;
  logic [31:0] fpu_a, fpu_b;
  logic [2:0]  fpu_frm;
  logic [3:0]  fpu_decode;
  logic        fpu_sub;
  logic [31:0] fpu_result;
  logic [4:0]  fpu_flags;
  logic        resp_valid, resp_ready;
  logic [31:0] resp_result;
  logic [4:0]  resp_flags, resp_rd;
  logic        resp_illegal;
  logic [4:0]  fflags;
  logic        fflags_clr;

  int checks = 0;
  int failures = 0;

  fpu_issue_ctrl #(.ADD_LAT(2), .MUL_LAT(3), .CVT_LAT(2), .MISC_LAT(1)) dut (
    .clk(clk), .reset(reset),
    .req_valid(req_valid), .req_ready(req_ready),
    .req_a(req_a), .req_b(req_b), .req_op(req_op), .req_sub(req_sub),
    .req_rm(req_rm), .req_rd(req_rd), .csr_frm(csr_frm),
    .fpu_a(fpu_a), .fpu_b(fpu_b), .fpu_frm(fpu_frm), .fpu_decode(fpu_decode),
    .fpu_sub(fpu_sub), .fpu_result(fpu_result), .fpu_flags(fpu_flags),
    .resp_valid(resp_valid), .resp_ready(resp_ready), .resp_result(resp_result),
    .resp_flags(resp_flags), .resp_rd(resp_rd), .resp_illegal(resp_illegal),
    .fflags(fflags), .fflags_clr(fflags_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic issue(input logic [3:0] op, input logic sub, input logic [2:0] rm,
                       input logic [4:0] rd, input logic [31:0] a, input logic [31:0] b);
    req_valid = 1'b1;
    req_op = op; req_sub = sub; req_rm = rm; req_rd = rd; req_a = a; req_b = b;
    tick();
    req_valid = 1'b0;
  endtask

  task automatic wait_resp(output int n);
    n = 0;
    while (!resp_valid && n < 40) begin
      tick();
      n++;
    end
  endtask

  task automatic retire();
    resp_ready = 1'b1;
    tick();
    resp_ready = 1'b0;
  endtask

  task automatic test_reset();
    reset = 1'b1;
    tick(); tick();
    if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_req_ready got=%b exp=1", req_ready); end
    checks++;
    if (resp_valid !== 1'b0) begin failures++; $display("FAIL rst_resp_valid got=%b exp=0", resp_valid); end
    checks++;
    if (fflags !== 5'b0) begin failures++; $display("FAIL rst_fflags got=%b exp=00000", fflags); end
    checks++;
    if ({fpu_a, fpu_b, fpu_frm, fpu_decode, fpu_sub} !== 72'h0) begin
      failures++; $display("FAIL rst_fpu_outs got=%h exp=0", {fpu_a, fpu_b, fpu_frm, fpu_decode, fpu_sub});
    end
    checks++;
    if ({resp_result, resp_flags, resp_rd, resp_illegal} !== 43'h0) begin
      failures++; $display("FAIL rst_resp_outs got=%h exp=0", {resp_result, resp_flags, resp_rd, resp_illegal});
    end
    checks++;
    reset = 1'b0;
    tick();
    if (req_ready !== 1'b1) begin failures++; $display("FAIL rst_rel_req_ready got=%b exp=1", req_ready); end
    checks++;
  endtask

  task automatic test_add();
    int n;
    fpu_result = 32'h4040_0000; fpu_flags = 5'b0;
    issue(4'd0, 1'b0, 3'b000, 5'd7, 32'h3F80_0000, 32'h4000_0000);
    if (req_ready !== 1'b0) begin failures++; $display("FAIL add_busy got=%b exp=0", req_ready); end
    checks++;
    if ({fpu_a, fpu_b, fpu_decode, fpu_frm, fpu_sub} !== {32'h3F80_0000, 32'h4000_0000, 4'd0, 3'b000, 1'b0}) begin
      failures++; $display("FAIL add_fpu_drive got=%h %h %h %b", fpu_a, fpu_b, fpu_decode, fpu_frm);
    end
    checks++;
    wait_resp(n);
    if (n !== 2) begin failures++; $display("FAIL add_latency got=%0d exp=2", n); end
    checks++;
    if (resp_result !== 32'h4040_0000) begin failures++; $display("FAIL add_result got=%h exp=40400000", resp_result); end
    checks++;
    if ({resp_flags, resp_rd, resp_illegal} !== {5'b0, 5'd7, 1'b0}) begin
      failures++; $display("FAIL add_resp got=%b/%0d/%b exp=00000/7/0", resp_flags, resp_rd, resp_illegal);
    end
    checks++;
    retire();
    if ({resp_valid, req_ready} !== 2'b01) begin
      failures++; $display("FAIL add_retire got=%b exp=01", {resp_valid, req_ready});
    end
    checks++;
  endtask

  task automatic test_mul_dyn();
    int n;
    fpu_result = 32'h40C0_0000; fpu_flags = 5'b0;
    csr_frm = 3'b001;
    issue(4'd3, 1'b0, 3'b111, 5'd12, 32'h4000_0000, 32'h4040_0000);
    csr_frm = 3'b100;
    n = 0;
    while (!resp_valid && n < 40) begin
      if (fpu_frm !== 3'b001) begin failures++; $display("FAIL mul_frm_hold got=%b exp=001", fpu_frm); end
      checks++;
      tick();
      n++;
    end
    if (n !== 3) begin failures++; $display("FAIL mul_latency got=%0d exp=3", n); end
    checks++;
    if ({resp_result, resp_rd} !== {32'h40C0_0000, 5'd12}) begin
      failures++; $display("FAIL mul_resp got=%h/%0d exp=40c00000/12", resp_result, resp_rd);
    end
    checks++;
    retire();
    csr_frm = 3'b000;
  endtask

  task automatic test_illegal();
    int n;
    logic [2:0] rms [3] = '{3'b101, 3'b111, 3'b000};
    logic [3:0] ops [3] = '{4'd0, 4'd0, 4'd9};
    fpu_result = 32'hFFFF_FFFF; fpu_flags = 5'b11111;
    csr_frm = 3'b110;
    for (int i = 0; i < 3; i++) begin
      issue(ops[i], 1'b0, rms[i], 5'(20 + i), 32'h1, 32'h2);
      wait_resp(n);
      if (n !== 1) begin failures++; $display("FAIL ill%0d_latency got=%0d exp=1", i, n); end
      checks++;
      if ({resp_illegal, resp_result, resp_flags, resp_rd} !== {1'b1, 32'h0, 5'b0, 5'(20 + i)}) begin
        failures++; $display("FAIL ill%0d_resp got=%b/%h/%b/%0d exp=1/0/0/%0d",
                             i, resp_illegal, resp_result, resp_flags, resp_rd, 20 + i);
      end
      checks++;
      if (fflags !== 5'b0) begin failures++; $display("FAIL ill%0d_fflags got=%b exp=00000", i, fflags); end
      checks++;
      retire();
    end
    csr_frm = 3'b000; fpu_flags = 5'b0;
  endtask

  task automatic test_backpressure();
    int n;
    fpu_result = 32'h4040_0000; fpu_flags = 5'b0;
    issue(4'd0, 1'b0, 3'b000, 5'd3, 32'h3F80_0000, 32'h4000_0000);
    wait_resp(n);
    fpu_result = 32'hDEAD_BEEF;
    req_valid = 1'b1; req_op = 4'd0; req_rd = 5'd9; req_rm = 3'b000;
    for (int i = 0; i < 5; i++) begin
      tick();
      if ({resp_valid, req_ready, resp_result, resp_rd} !== {1'b1, 1'b0, 32'h4040_0000, 5'd3}) begin
        failures++; $display("FAIL bp_hold%0d got=%b%b/%h/%0d exp=10/40400000/3",
                             i, resp_valid, req_ready, resp_result, resp_rd);
      end
      checks++;
    end
    retire();
    if ({resp_valid, req_ready} !== 2'b01) begin
      failures++; $display("FAIL bp_after_retire got=%b exp=01", {resp_valid, req_ready});
    end
    checks++;
    tick();
    req_valid = 1'b0;
    if (req_ready !== 1'b0) begin failures++; $display("FAIL bp_accept got=%b exp=0", req_ready); end
    checks++;
    wait_resp(n);
    if ({n, resp_rd, resp_result} !== {32'd2, 5'd9, 32'hDEAD_BEEF}) begin
      failures++; $display("FAIL bp_second got=%0d/%0d/%h exp=2/9/deadbeef", n, resp_rd, resp_result);
    end
    checks++;
    retire();
  endtask

  task automatic test_fflags();
    int n;
    fpu_result = 32'h1; fpu_flags = 5'b00001;
    issue(4'd1, 1'b0, 3'b000, 5'd1, 32'h3FC0_0000, 32'h0);
    wait_resp(n);
    if ({n, resp_flags, fflags} !== {32'd2, 5'b00001, 5'b00001}) begin
      failures++; $display("FAIL f2i_nx got=%0d/%b/%b exp=2/00001/00001", n, resp_flags, fflags);
    end
    checks++;
    retire();
    fpu_result = 32'h7FFF_FFFF; fpu_flags = 5'b10000;
    issue(4'd1, 1'b0, 3'b000, 5'd2, 32'h7FC0_0000, 32'h0);
    wait_resp(n);
    if (fflags !== 5'b10001) begin failures++; $display("FAIL f2i_nv_accrue got=%b exp=10001", fflags); end
    checks++;
    retire();
    fpu_result = 32'h1; fpu_flags = 5'b00001;
    issue(4'd1, 1'b0, 3'b000, 5'd4, 32'h3FC0_0000, 32'h0);
    tick();
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    if ({resp_valid, fflags} !== {1'b1, 5'b00001}) begin
      failures++; $display("FAIL clr_on_capture got=%b/%b exp=1/00001", resp_valid, fflags);
    end
    checks++;
    retire();
    fflags_clr = 1'b1;
    tick();
    fflags_clr = 1'b0;
    if (fflags !== 5'b0) begin failures++; $display("FAIL clr_idle got=%b exp=00000", fflags); end
    checks++;
  endtask

  task automatic test_reset_mid();
    int n;
    fpu_result = 32'h0; fpu_flags = 5'b00010;
    issue(4'd4, 1'b0, 3'b000, 5'd5, 32'h1, 32'h2);
    wait_resp(n);
    if ({n, fflags} !== {32'd1, 5'b00010}) begin
      failures++; $display("FAIL misc_op got=%0d/%b exp=1/00010", n, fflags);
    end
    checks++;
    retire();
    fpu_flags = 5'b11111;
    issue(4'd3, 1'b0, 3'b000, 5'd6, 32'h4000_0000, 32'h4040_0000);
    tick();
    reset = 1'b1;
    #1;
    if ({req_ready, resp_valid, fflags, fpu_a} !== {1'b1, 1'b0, 5'b0, 32'h0}) begin
      failures++; $display("FAIL mid_reset got=%b%b/%b/%h exp=10/00000/0", req_ready, resp_valid, fflags, fpu_a);
    end
    checks++;
    tick();
    reset = 1'b0;
    for (int i = 0; i < 4; i++) begin
      tick();
      if ({resp_valid, fflags} !== {1'b0, 5'b0}) begin
        failures++; $display("FAIL post_reset%0d got=%b/%b exp=0/00000", i, resp_valid, fflags);
      end
      checks++;
    end
    fpu_result = 32'h4040_0000; fpu_flags = 5'b0;
    issue(4'd0, 1'b0, 3'b000, 5'd8, 32'h3F80_0000, 32'h4000_0000);
    wait_resp(n);
    if ({n, resp_result, resp_rd, fflags} !== {32'd2, 32'h4040_0000, 5'd8, 5'b0}) begin
      failures++; $display("FAIL after_reset_op got=%0d/%h/%0d/%b exp=2/40400000/8/00000",
                           n, resp_result, resp_rd, fflags);
    end
    checks++;
    retire();
  endtask

  initial begin
    reset = 1'b1; req_valid = 1'b0; req_a = '0; req_b = '0; req_op = '0; req_sub = 1'b0;
    req_rm = '0; req_rd = '0; csr_frm = '0; fpu_result = '0; fpu_flags = '0;
    resp_ready = 1'b0; fflags_clr = 1'b0;
    test_reset();
    test_add();
    test_mul_dyn();
    test_illegal();
    test_backpressure();
    test_fflags();
    test_reset_mid();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
